debug_dump: RTL and testbench
=============================

# debug_dump

Debug-interface consumer that sits directly downstream of the 18-bit `processor`. When the core halts with `wait_for_continue` high, the block reads r0..r7 and ip through the processor debug port. It streams them as a framed byte sequence over a valid/ready byte interface to a UART or host-link transmitter, then releases the core by pulsing `wait_continue_execution`.

## Interface
- `WORD_SIZE`, 18: debug word width; must be 18. Each word is serialized as 3 bytes.
- `NUM_REGS`, 8: general registers dumped before ip (ip is debug address `NUM_REGS`).
- `clock` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `wait_for_continue` in 1: processor halted and awaiting continue.
- `wait_continue_execution` out 1: one-cycle release pulse to the processor.
- `debug_get_param` out 1: debug read enable to the processor.
- `debug_reg_addr` out 4: debug address; 0..7 are r0..r7, 8 is ip.
- `debug_data_in` in WORD_SIZE: processor `debug_data_out`.
- `tx_data` out 8: outgoing byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: sink accepts a byte when `tx_valid && tx_ready` at a rising edge.
- `continue_request` in 1: host release request (see Configuration).
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame contents:
  - Header byte 0xA5.
  - 9 words (r0..r7, ip), each big-endian in 3 bytes: {6'b0, w[17:16]}, w[15:8], w[7:0].
  - Checksum byte: 8-bit sum mod 256 of the 27 word bytes, header excluded.
  - Total 29 bytes.
- FSM states: IDLE, HEADER, SETUP, CAPTURE, SEND (byte index 0..2), CHECK, HOLD, RELEASE, DRAIN.
- IDLE: when `wait_for_continue`=1, go to HEADER and clear word index and checksum.
- HEADER: `tx_valid`=1, `tx_data`=0xA5. On accept, go to SETUP.
- SETUP: drive `debug_get_param`=1 and `debug_reg_addr`=word index; hold for one cycle, then go to CAPTURE.
- CAPTURE: latch `debug_data_in` into an 18-bit shadow register, then go to SEND with byte index 0.
- SEND:
  - Present the shadow byte selected by the byte index.
  - On accept, add the byte to the checksum and advance the byte index.
  - After byte 2, either go to SETUP with the next word index (index < 8), or go to CHECK (index = 8).
- CHECK: present the checksum byte. On accept, go to HOLD.
- HOLD: wait for release per Configuration, then go to RELEASE.
- RELEASE: `wait_continue_execution`=1 for exactly one cycle, then go to DRAIN.
- DRAIN: wait until `wait_for_continue`=0, then go to IDLE. The same halt is never dumped twice.
- `debug_get_param` is high in SETUP and CAPTURE only. `debug_reg_addr` holds its last value elsewhere.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold stable. `tx_valid` never drops before accept.
- `continue_request` is level-sampled, and only in HOLD.
- If `wait_for_continue` falls mid-frame, the frame still completes; the RELEASE pulse is still issued.

## Timing
- Reset values: `wait_continue_execution`=0, `debug_get_param`=0, `debug_reg_addr`=0, `tx_valid`=0, `tx_data`=0x00, `busy`=0. FSM goes to IDLE; checksum and shadow register are cleared.
- Reset asserted mid-frame abandons the frame. Outputs reach reset values at the next edge, and no release pulse is issued.
- `wait_for_continue` is sampled high at edge N:
  - `tx_valid`=1 with 0xA5 after edge N.
  - With `tx_ready` held at 1, the header is accepted at edge N+1.
- Per word: 2 cycles of debug read (SETUP, CAPTURE) plus 3 byte cycles when `tx_ready`=1. `debug_data_in` is sampled one full cycle after `debug_reg_addr` changes.
- Full frame with `tx_ready` tied to 1: 1 + 9×5 + 1 = 47 cycles from edge N to the checksum accept.
- With auto-continue, the RELEASE pulse is high during the cycle following HOLD: exactly 1 cycle, 2 edges after the checksum accept.
- Back-pressure stretches only the byte states and never re-reads the debug port.

## Configuration
- `DEBUG_DUMP_AUTO_CONTINUE_EN`, when defined:
  - HOLD passes straight to RELEASE after one cycle.
  - `continue_request` is ignored, and the processor resumes automatically after every dump.
- When undefined: HOLD waits indefinitely for `continue_request`=1, then goes to RELEASE.

## Test plan
- All registers and ip = 0, `tx_ready`=1 -> 29 bytes: A5, 27×00, checksum 00. One release pulse; `busy` drops after `wait_for_continue` falls.
- r1=0x3FFFF, others 0 -> bytes 4..6 = 03 FF FF; checksum = 0x01.
- ip=0x12345, `tx_ready` toggling 1/0 every cycle -> ip bytes 01 23 45. `tx_data` stable across every stall; byte count exactly 29.
- Without the macro: frame completes, `continue_request` held 0 for 20 cycles -> no pulse. Raise it -> exactly one 1-cycle `wait_continue_execution` pulse.
- `wait_for_continue` held high after release -> no second frame until it drops and rises again.
- `reset` asserted during the byte for r4 -> all outputs 0 next cycle. A new halt yields a complete fresh frame starting with A5.

Source files
------------

// File: rtl/debug_dump.sv
// debug_dump: on a processor halt, reads r0..r7 and ip over the debug port, streams
// them as a framed byte sequence (A5, 27 word bytes, checksum), then releases the core.
// Optional build macro DEBUG_DUMP_AUTO_CONTINUE_EN: release automatically after every dump.
module debug_dump #(
   parameter int WORD_SIZE = 18,
   parameter int NUM_REGS  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wait_for_continue,
   output logic                 wait_continue_execution,
   output logic                 debug_get_param,
   output logic [3:0]           debug_reg_addr,
   input  logic [WORD_SIZE-1:0] debug_data_in,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   input  logic                 continue_request,
   output logic                 busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_HEADER,
      S_SETUP,
      S_CAPTURE,
      S_SEND,
      S_CHECK,
      S_HOLD,
      S_RELEASE,
      S_DRAIN
   } state_t;

   localparam logic [7:0] HDR_BYTE  = 8'hA5;
   localparam logic [3:0] LAST_WORD = 4'(NUM_REGS);

   state_t                 state;
   state_t                 state_nxt;
   logic [3:0]             word_idx;
   logic [3:0]             addr_q;
   logic [1:0]             byte_idx;
   logic [WORD_SIZE-1:0]   shadow;
   logic [7:0]             checksum;
   logic [7:0]             send_byte;

   // Big-endian byte select out of the captured word; top byte carries only bits 17:16.
   always_comb begin
      case (byte_idx)
         2'd0:    send_byte = {6'b0, shadow[17:16]};
         2'd1:    send_byte = shadow[15:8];
         default: send_byte = shadow[7:0];
      endcase
   end

   // The address is live during SETUP and otherwise holds the last address read.
   assign debug_reg_addr = (state == S_SETUP) ? word_idx : addr_q;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and output decode; tx outputs depend only on state so they hold during stalls.
   always_comb begin
      state_nxt               = state;
      tx_valid                = 1'b0;
      tx_data                 = 8'h00;
      debug_get_param         = 1'b0;
      wait_continue_execution = 1'b0;
      busy                    = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (wait_for_continue) state_nxt = S_HEADER;
         end
         S_HEADER: begin
            tx_valid = 1'b1;
            tx_data  = HDR_BYTE;
            if (tx_ready) state_nxt = S_SETUP;
         end
         S_SETUP: begin
            debug_get_param = 1'b1;
            state_nxt       = S_CAPTURE;
         end
         S_CAPTURE: begin
            debug_get_param = 1'b1;
            state_nxt       = S_SEND;
         end
         S_SEND: begin
            tx_valid = 1'b1;
            tx_data  = send_byte;
            if (tx_ready && byte_idx == 2'd2)
               state_nxt = (word_idx == LAST_WORD) ? S_CHECK : S_SETUP;
         end
         S_CHECK: begin
            tx_valid = 1'b1;
            tx_data  = checksum;
            if (tx_ready) state_nxt = S_HOLD;
         end
         S_HOLD: begin
`ifdef DEBUG_DUMP_AUTO_CONTINUE_EN
            state_nxt = S_RELEASE;
`else
            if (continue_request) state_nxt = S_RELEASE;
`endif
         end
         S_RELEASE: begin
            wait_continue_execution = 1'b1;
            state_nxt               = S_DRAIN;
         end
         S_DRAIN: begin
            if (!wait_for_continue) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: word/byte counters, shadow capture, running checksum, held debug address.
   always_ff @(posedge clock) begin
      if (reset) begin
         word_idx <= 4'd0;
         addr_q   <= 4'd0;
         byte_idx <= 2'd0;
         shadow   <= '0;
         checksum <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (wait_for_continue) begin
                  word_idx <= 4'd0;
                  byte_idx <= 2'd0;
                  checksum <= 8'h00;
               end
            end
            S_SETUP: addr_q <= word_idx;
            S_CAPTURE: begin
               shadow   <= debug_data_in;
               byte_idx <= 2'd0;
            end
            S_SEND: begin
               if (tx_ready) begin
                  checksum <= checksum + send_byte;
                  if (byte_idx == 2'd2) begin
                     byte_idx <= 2'd0;
                     if (word_idx != LAST_WORD) word_idx <= word_idx + 4'd1;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_dump.sv
// Bench for debug_dump: randomized register contents and sink back-pressure, frames
// checked byte-by-byte against an arithmetic frame model, plus release/drain/reset behaviour.
module tb_debug_dump;

   logic        clock = 1'b0;
   logic        reset;
   logic        wait_for_continue;
   logic        wait_continue_execution;
   logic        debug_get_param;
   logic [3:0]  debug_reg_addr;
   logic [17:0] debug_data_in;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        continue_request;
   logic        busy;

   logic [17:0] regs [16];
   logic [7:0]  exp_b [29];
   int          checks   = 0;
   int          failures = 0;

   always #5 clock = ~clock;

   debug_dump #(.WORD_SIZE(18), .NUM_REGS(8)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .wait_for_continue      (wait_for_continue),
      .wait_continue_execution(wait_continue_execution),
      .debug_get_param        (debug_get_param),
      .debug_reg_addr         (debug_reg_addr),
      .debug_data_in          (debug_data_in),
      .tx_data                (tx_data),
      .tx_valid               (tx_valid),
      .tx_ready               (tx_ready),
      .continue_request       (continue_request),
      .busy                   (busy)
   );

   // Processor debug port model: registered read of the addressed register.
   always_ff @(posedge clock) debug_data_in <= regs[debug_reg_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Expected frame computed from the register file with plain arithmetic.
   task automatic build_expected();
      int sum;
      int v;
      sum = 0;
      exp_b[0] = 8'hA5;
      for (int w = 0; w < 9; w++) begin
         v = int'(regs[w]);
         exp_b[1 + 3*w] = 8'(v / 65536);
         exp_b[2 + 3*w] = 8'((v / 256) % 256);
         exp_b[3 + 3*w] = 8'(v % 256);
         sum += v / 65536 + (v / 256) % 256 + v % 256;
      end
      exp_b[28] = 8'(sum % 256);
   endtask

   // mode 0: ready always; 1: ready toggles; 2: random ready and wfc drops mid-frame.
   task automatic do_frame(input int mode, input int stop_at);
      logic [7:0] got[$];
      int         reads;
      int         pulses;
      int         accept_edge;
      logic       stalled;
      logic [7:0] held;
      build_expected();
      reads = 0; pulses = 0; accept_edge = -1; stalled = 1'b0; held = 8'h00;
      wait_for_continue = 1'b1;
      tick();
      check("hdr_vld", 32'(tx_valid), 32'd1);
      check("hdr_dat", 32'(tx_data), 32'hA5);
      for (int k = 0; k < 2000 && got.size() < stop_at; k++) begin
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (k % 2 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         if (mode == 2 && k == 30) wait_for_continue = 1'b0;
         #1;
         if (debug_get_param) reads++;
         if (wait_continue_execution) pulses++;
         if (stalled) begin
            check("stall_vld", 32'(tx_valid), 32'd1);
            check("stall_dat", 32'(tx_data), 32'(held));
         end
         if (tx_valid && tx_ready) begin
            got.push_back(tx_data);
            if (got.size() == 29) accept_edge = k + 1;
         end
         stalled = tx_valid && !tx_ready;
         held    = tx_data;
         tick();
      end
      if (stop_at == 29) begin
         check("nbytes", 32'(got.size()), 32'd29);
         check("reads", 32'(reads), 32'd18);
         check("frame_pulse", 32'(pulses), 32'd0);
         if (mode == 0) check("frame_lat", 32'(accept_edge), 32'd47);
         foreach (got[i]) check($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_b[i]));
      end
   endtask

   task automatic release_core(input int hold_cycles, input int drain_cycles);
      int pulses;
      int first;
      int vld_cnt;
      int idle_cnt;
      pulses = 0; first = -1; vld_cnt = 0; idle_cnt = 0;
`ifndef DEBUG_DUMP_AUTO_CONTINUE_EN
      continue_request = 1'b0;
      for (int i = 0; i < hold_cycles; i++) begin
         if (wait_continue_execution) pulses++;
         tick();
      end
      check("no_early_pulse", 32'(pulses), 32'd0);
      continue_request = 1'b1;
`endif
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (wait_continue_execution) begin
            pulses++;
            if (first < 0) first = i;
         end
         continue_request = 1'b0;
         if (i >= 2 && drain_cycles > 0) begin
            if (tx_valid) vld_cnt++;
            if (!busy) idle_cnt++;
         end
      end
      check("pulse_cnt", 32'(pulses), 32'd1);
      check("pulse_when", 32'(first), 32'd0);
      for (int i = 0; i < drain_cycles; i++) begin
         if (tx_valid) vld_cnt++;
         if (!busy) idle_cnt++;
         tick();
      end
      if (drain_cycles > 0) begin
         check("drain_no_tx", 32'(vld_cnt), 32'd0);
         check("drain_busy", 32'(idle_cnt), 32'd0);
      end
      wait_for_continue = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 18'h0;
      reset = 1'b1; wait_for_continue = 1'b0; tx_ready = 1'b0; continue_request = 1'b0;
      tick(); tick();
      check("rst_vld",  32'(tx_valid), 32'd0);
      check("rst_dat",  32'(tx_data), 32'd0);
      check("rst_gp",   32'(debug_get_param), 32'd0);
      check("rst_addr", 32'(debug_reg_addr), 32'd0);
      check("rst_wce",  32'(wait_continue_execution), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // All zeros, ready tied high, core kept halted through drain.
      do_frame(0, 29);
      release_core(20, 20);

      // r1 all ones.
      regs[1] = 18'h3FFFF;
      do_frame(0, 29);
      release_core(3, 0);

      // ip pattern with alternating back-pressure.
      regs[1] = 18'h0;
      regs[8] = 18'h12345;
      do_frame(1, 29);
      release_core(2, 0);

      // Random registers and random back-pressure.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 9; i++) regs[i] = 18'($urandom);
         do_frame(2, 29);
         release_core($urandom_range(0, 5), 0);
      end

      // Reset during r4's bytes, then a fresh frame.
      for (int i = 0; i < 9; i++) regs[i] = 18'($urandom);
      do_frame(0, 14);
      reset = 1'b1;
      wait_for_continue = 1'b0;
      tick();
      check("mid_rst_vld",  32'(tx_valid), 32'd0);
      check("mid_rst_dat",  32'(tx_data), 32'd0);
      check("mid_rst_gp",   32'(debug_get_param), 32'd0);
      check("mid_rst_addr", 32'(debug_reg_addr), 32'd0);
      check("mid_rst_wce",  32'(wait_continue_execution), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();
      check("post_rst_wce", 32'(wait_continue_execution), 32'd0);
      do_frame(0, 29);
      release_core(1, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
